uart_tx_serializer: RTL and testbench

- UART transmit path, the counterpart of the UART RX chain. It serializes a parallel byte into a standard frame: start bit, data LSB-first, optional parity, stop bit.
- Each bit is held for PRESCALE clock cycles. This matches the RX oversampling ratio so both ends share one CLK and prescale setting.
- Sits between the system-side TX data source (FIFO or register file) and the TX_OUT pad.

---
 rtl/uart_tx_serializer_if.sv | 21 ++
 rtl/uart_tx_serializer.sv | 134 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Parallel-byte request / serial-line bundle between a TX data source and the UART serializer.
interface uart_tx_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit,
// each bit held PRESCALE clocks. TX_OUT and Busy come straight from flops.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_tx_serializer_if.slave   bus
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q,   nxt_state;
    logic [CW-1:0]         edge_q,    nxt_edge;
    logic [BW-1:0]         bit_q,     nxt_bit;
    logic [DATA_WIDTH-1:0] data_q,    nxt_data;
    logic                  par_en_q,  nxt_par_en;
    logic                  par_bit_q, nxt_par_bit;
    logic                  load_q,    nxt_load;
    logic                  tx_q,      nxt_tx;
    logic                  busy_q,    nxt_busy;

    logic bit_done_c;
    logic last_bit_c;

    assign bit_done_c = (edge_q == CW'(PRESCALE - 1));
    assign last_bit_c = (bit_q == BW'(DATA_WIDTH - 1));

    // State and datapath registers; reset aborts any frame and parks the line high
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            load_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= nxt_state;
            edge_q    <= nxt_edge;
            bit_q     <= nxt_bit;
            data_q    <= nxt_data;
            par_en_q  <= nxt_par_en;
            par_bit_q <= nxt_par_bit;
            load_q    <= nxt_load;
            tx_q      <= nxt_tx;
            busy_q    <= nxt_busy;
        end
    end

    // Next state, word latch and next registered line level
    always_comb begin
        nxt_state   = state_q;
        nxt_edge    = '0;
        nxt_bit     = bit_q;
        nxt_data    = data_q;
        nxt_par_en  = par_en_q;
        nxt_par_bit = par_bit_q;
        nxt_load    = 1'b0;
        nxt_tx      = 1'b1;
        nxt_busy    = 1'b0;

        if (state_q != S_IDLE) begin
            nxt_edge = bit_done_c ? '0 : edge_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                // Word is latched one cycle ahead of the start bit
                if (load_q) begin
                    nxt_state = S_START;
                end else if (bus.Data_Valid) begin
                    nxt_data    = bus.P_DATA;
                    nxt_par_en  = bus.PAR_EN;
                    nxt_par_bit = (^bus.P_DATA) ^ bus.PAR_TYP;
                    nxt_load    = 1'b1;
                end
            end
            S_START: begin
                if (bit_done_c) nxt_state = S_DATA;
            end
            S_DATA: begin
                if (bit_done_c) begin
                    if (last_bit_c) begin
                        nxt_bit   = '0;
                        nxt_state = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        nxt_bit = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_done_c) nxt_state = S_STOP;
            end
            S_STOP: begin
                // Back-to-back word skips the idle/latch cycle entirely
                if (bit_done_c) begin
                    if (bus.Data_Valid) begin
                        nxt_data    = bus.P_DATA;
                        nxt_par_en  = bus.PAR_EN;
                        nxt_par_bit = (^bus.P_DATA) ^ bus.PAR_TYP;
                        nxt_state   = S_START;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end
            end
            default: nxt_state = S_IDLE;
        endcase

        case (nxt_state)
            S_START:  nxt_tx = 1'b0;
            S_DATA:   nxt_tx = nxt_data[nxt_bit];
            S_PARITY: nxt_tx = nxt_par_bit;
            default:  nxt_tx = 1'b1;
        endcase
        nxt_busy = (nxt_state != S_IDLE);
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: expected (line, busy) per cycle is queued at stimulus time and
// compared on falling edges against a PRESCALE=8 and a PRESCALE=1 instance.
module tb_uart_tx_serializer;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic tx;
        logic busy;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    uart_tx_serializer_if #(.DATA_WIDTH(DW)) b8 ();
    uart_tx_serializer_if #(.DATA_WIDTH(DW)) b1 ();

    uart_tx_serializer #(.DATA_WIDTH(DW), .PRESCALE(8)) dut8 (
        .CLK (CLK),
        .RST (RST),
        .bus (b8)
    );

    uart_tx_serializer #(.DATA_WIDTH(DW), .PRESCALE(1)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (b1)
    );

    task automatic check(input string tag, input logic otx, input logic obusy, input exp_t e);
        checks++;
        assert ({otx, obusy} === {e.tx, e.busy})
        else begin
            errors++;
            $error("FAIL %s: observed tx=%b busy=%b expected tx=%b busy=%b",
                   tag, otx, obusy, e.tx, e.busy);
        end
    endtask

    task automatic drive(input int which, input logic dv, input logic [DW-1:0] d,
                         input logic pe, input logic pt);
        if (which == 1) begin
            b1.Data_Valid = dv; b1.P_DATA = d; b1.PAR_EN = pe; b1.PAR_TYP = pt;
        end else begin
            b8.Data_Valid = dv; b8.P_DATA = d; b8.PAR_EN = pe; b8.PAR_TYP = pt;
        end
    endtask

    // Present a word so that it is sampled on exactly one rising edge (unless held)
    task automatic send(input int which, input logic [DW-1:0] d, input logic pe,
                        input logic pt, input logic hold);
        @(posedge CLK);
        #1 drive(which, 1'b1, d, pe, pt);
        @(posedge CLK);
        #1 if (!hold) drive(which, 1'b0, d, pe, pt);
    endtask

    task automatic push(input logic tx, input logic busy, input int n);
        exp_t e;
        e.tx   = tx;
        e.busy = busy;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic push_frame(input int ps, input logic [DW-1:0] d, input logic pe,
                              input logic pt);
        push(1'b0, 1'b1, ps);
        for (int i = 0; i < DW; i++) push(d[i], 1'b1, ps);
        if (pe) push((^d) ^ pt, 1'b1, ps);
        push(1'b1, 1'b1, ps);
    endtask

    task automatic drain(input int which, input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (sb.size() == 0) begin
                e.tx   = 1'bx;
                e.busy = 1'bx;
            end else begin
                e = sb.pop_front();
            end
            if (which == 1) check(tag, b1.TX_OUT, b1.Busy, e);
            else            check(tag, b8.TX_OUT, b8.Busy, e);
        end
    endtask

    // Idle cycle while the word is latched, the frame, then one idle cycle
    task automatic frame_test(input int which, input logic [DW-1:0] d, input logic pe,
                              input logic pt, input string tag);
        send(which, d, pe, pt, 1'b0);
        push(1'b1, 1'b0, 1);
        push_frame((which == 1) ? 1 : 8, d, pe, pt);
        push(1'b1, 1'b0, 1);
        drain(which, sb.size(), tag);
    endtask

    initial begin
        exp_t idle_e;
        idle_e.tx   = 1'b1;
        idle_e.busy = 1'b0;

        RST = 1'b1;
        drive(8, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        check("reset_p8", b8.TX_OUT, b8.Busy, idle_e);
        check("reset_p1", b1.TX_OUT, b1.Busy, idle_e);
        @(negedge CLK);
        RST = 1'b0;
        drain(8, 0, "none");
        push(1'b1, 1'b0, 3);
        drain(8, 3, "idle_after_reset");

        frame_test(8, 8'hA5, 1'b0, 1'b0, "a5_nopar");
        frame_test(8, 8'hA5, 1'b1, 1'b0, "a5_even");
        frame_test(8, 8'hA5, 1'b1, 1'b1, "a5_odd");
        frame_test(8, 8'h00, 1'b1, 1'b1, "00_odd");
        frame_test(8, 8'hFF, 1'b1, 1'b0, "ff_even");

        // Back-to-back: Data_Valid held, next word swapped in mid-frame
        send(8, 8'h3C, 1'b0, 1'b0, 1'b1);
        push(1'b1, 1'b0, 1);
        push_frame(8, 8'h3C, 1'b0, 1'b0);
        push_frame(8, 8'hC3, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1);
        drain(8, 41, "b2b");
        b8.P_DATA = 8'hC3;
        drain(8, 80, "b2b");
        b8.Data_Valid = 1'b0;
        drain(8, sb.size(), "b2b");

        // Request and parity-type change during DATA must not disturb the frame
        send(8, 8'h12, 1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1);
        push_frame(8, 8'h12, 1'b1, 1'b0);
        push(1'b1, 1'b0, 5);
        drain(8, 1 + 8 + 3 * 8, "ignore_busy");
        b8.Data_Valid = 1'b1;
        b8.P_DATA     = 8'hFF;
        b8.PAR_TYP    = 1'b1;
        drain(8, 1, "ignore_busy");
        b8.Data_Valid = 1'b0;
        drain(8, sb.size(), "ignore_busy");

        // Asynchronous reset in the middle of DATA
        b8.PAR_TYP = 1'b0;
        send(8, 8'hA5, 1'b0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1);
        push_frame(8, 8'hA5, 1'b0, 1'b0);
        drain(8, 1 + 8 + 3 * 8 + 4, "pre_reset");
        RST = 1'b1;
        #1 check("async_reset", b8.TX_OUT, b8.Busy, idle_e);
        sb.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        push(1'b1, 1'b0, 10);
        drain(8, 10, "idle_post_reset");

        frame_test(1, 8'h81, 1'b1, 1'b1, "p1_81_odd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
